// File: rtl/event_dec_pkg.sv
// Shared definitions for the one-hot event decoder: default index width,
// FSM state encoding and the pulse-length/counter-width legality check.
package event_dec_pkg;

  localparam int IDX_W_DEF     = 3;
  localparam int PULSE_LEN_MAX = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_t;

  // The counter must be able to hold PULSE_LEN-1 and the length must be 1..15.
  function automatic bit pulse_cfg_ok(input int pulse_len, input int cnt_w);
    return (pulse_len >= 1) && (pulse_len <= PULSE_LEN_MAX) &&
           ((1 << cnt_w) > pulse_len);
  endfunction

endpackage

// File: rtl/onehot_event_decoder_if.sv
// Encoded event bus: producer offers an index with idx_valid, the decoder
// answers with idx_ready.
interface onehot_event_decoder_if
  import event_dec_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) ();

  logic             idx_valid;
  logic [IDX_W-1:0] idx;
  logic             idx_ready;

  modport master (
    output idx_valid,
    output idx,
    input  idx_ready
  );

  modport slave (
    input  idx_valid,
    input  idx,
    output idx_ready
  );

endinterface

// File: rtl/dec_onehot.sv
// Combinational IDX_W-to-N_OUT one-hot decoder; output is all-zero while en
// is low so an undriven index never reaches the result.
module dec_onehot #(
  parameter int IDX_W = 3,
  parameter int N_OUT = 2 ** IDX_W
) (
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [N_OUT-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/onehot_event_decoder.sv
// Decodes accepted event indices into a fixed-length one-hot strobe and
// sticky per-line pending flags with ack clearing and overflow detection.
module onehot_event_decoder
  import event_dec_pkg::*;
#(
  parameter int  IDX_W     = IDX_W_DEF,
  parameter int  PULSE_LEN = 2,
  parameter int  CNT_W     = 4,
  localparam int N_OUT     = 2 ** IDX_W
) (
  input  logic                   clk,
  input  logic                   reset,
  onehot_event_decoder_if.slave  bus,
  input  logic                   enable,
  input  logic [N_OUT-1:0]       ack,
  input  logic                   ovf_clr,
  output logic [N_OUT-1:0]       strobe,
  output logic [N_OUT-1:0]       pending,
  output logic                   busy,
  output logic                   overflow
);

  generate
    if (!pulse_cfg_ok(PULSE_LEN, CNT_W)) begin : g_cfg_err
      $error("onehot_event_decoder: PULSE_LEN must be 1..15 and fit in CNT_W bits");
    end
  endgenerate

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             xfer;
  logic             set_en;
  logic [N_OUT-1:0] set_vec;
  logic             ovf_hit;

  assign bus.idx_ready = (state == IDLE) && !reset;
  assign xfer          = bus.idx_valid && bus.idx_ready;
  assign set_en        = xfer && enable;

  // One decoder feeds both the pending set vector and the strobe load value.
  dec_onehot #(
    .IDX_W (IDX_W),
    .N_OUT (N_OUT)
  ) u_dec (
    .en     (set_en),
    .idx    (bus.idx),
    .onehot (set_vec)
  );

  assign ovf_hit = |(set_vec & pending & ~ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      strobe   <= '0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= (pending & ~ack) | set_vec;

      if (ovf_hit) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (set_en) begin
            state  <= PULSE;
            strobe <= set_vec;
            cnt    <= CNT_W'(PULSE_LEN - 1);
            busy   <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            state  <= IDLE;
            strobe <= '0;
            busy   <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          strobe <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_event_decoder.sv
// Bench for onehot_event_decoder: directed scenarios on a PULSE_LEN=2 and a
// PULSE_LEN=4 instance, then randomized traffic against a cycle-numbered model.
module tb_onehot_event_decoder;

  localparam int PL_A = 2;
  localparam int PL_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  onehot_event_decoder_if #(.IDX_W(3)) a_bus ();
  onehot_event_decoder_if #(.IDX_W(3)) b_bus ();

  logic       a_rst, a_en, a_clr, a_busy, a_ovf;
  logic [7:0] a_ack, a_strobe, a_pend;
  logic       b_rst, b_en, b_clr, b_busy, b_ovf;
  logic [7:0] b_ack, b_strobe, b_pend;

  onehot_event_decoder #(.IDX_W(3), .PULSE_LEN(PL_A), .CNT_W(4)) dut_a (
    .clk      (clk),
    .reset    (a_rst),
    .bus      (a_bus),
    .enable   (a_en),
    .ack      (a_ack),
    .ovf_clr  (a_clr),
    .strobe   (a_strobe),
    .pending  (a_pend),
    .busy     (a_busy),
    .overflow (a_ovf)
  );

  onehot_event_decoder #(.IDX_W(3), .PULSE_LEN(PL_B), .CNT_W(4)) dut_b (
    .clk      (clk),
    .reset    (b_rst),
    .bus      (b_bus),
    .enable   (b_en),
    .ack      (b_ack),
    .ovf_clr  (b_clr),
    .strobe   (b_strobe),
    .pending  (b_pend),
    .busy     (b_busy),
    .overflow (b_ovf)
  );

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [2:0] i, input logic e,
                         input logic [7:0] k, input logic c);
    a_bus.idx_valid = v;
    a_bus.idx       = i;
    a_en            = e;
    a_ack           = k;
    a_clr           = c;
  endtask

  task automatic b_drive(input logic v, input logic [2:0] i, input logic [7:0] k);
    b_bus.idx_valid = v;
    b_bus.idx       = i;
    b_en            = 1'b1;
    b_ack           = k;
    b_clr           = 1'b0;
  endtask

  task automatic test_reset();
    a_rst = 1'b1;
    b_rst = 1'b1;
    a_drive(1'b0, 3'd0, 1'b1, 8'h00, 1'b0);
    b_drive(1'b0, 3'd0, 8'h00);
    next_cyc();
    @(negedge clk);
    n_chk++; if (a_bus.idx_ready !== 1'b0) $display("FAIL reset_ready_low: got %b want 0", a_bus.idx_ready); else n_pass++;
    next_cyc();
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);
    n_chk++; if (a_strobe !== 8'h00) $display("FAIL reset_strobe: got %h want 00", a_strobe); else n_pass++;
    n_chk++; if (a_pend !== 8'h00) $display("FAIL reset_pending: got %h want 00", a_pend); else n_pass++;
    n_chk++; if ({a_busy, a_ovf} !== 2'b00) $display("FAIL reset_busy_ovf: got %b want 00", {a_busy, a_ovf}); else n_pass++;
    n_chk++; if (a_bus.idx_ready !== 1'b1) $display("FAIL reset_ready_high: got %b want 1", a_bus.idx_ready); else n_pass++;
    n_chk++; if (b_strobe !== 8'h00) $display("FAIL reset_b_strobe: got %h want 00", b_strobe); else n_pass++;
  endtask

  task automatic test_basic();
    next_cyc();
    a_drive(1'b1, 3'd5, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    n_chk++; if (a_bus.idx_ready !== 1'b1) $display("FAIL basic_ready: got %b want 1", a_bus.idx_ready); else n_pass++;
    next_cyc();
    a_drive(1'b0, 3'd0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    n_chk++; if (a_strobe !== 8'h20) $display("FAIL basic_strobe1: got %h want 20", a_strobe); else n_pass++;
    n_chk++; if (a_pend !== 8'h20) $display("FAIL basic_pending: got %h want 20", a_pend); else n_pass++;
    n_chk++; if ({a_busy, a_bus.idx_ready} !== 2'b10) $display("FAIL basic_busy1: got %b want 10", {a_busy, a_bus.idx_ready}); else n_pass++;
    next_cyc();
    @(negedge clk);
    n_chk++; if ({a_strobe, a_busy} !== {8'h20, 1'b1}) $display("FAIL basic_strobe2: got %h/%b want 20/1", a_strobe, a_busy); else n_pass++;
    next_cyc();
    @(negedge clk);
    n_chk++; if ({a_strobe, a_busy} !== {8'h00, 1'b0}) $display("FAIL basic_end: got %h/%b want 00/0", a_strobe, a_busy); else n_pass++;
    n_chk++; if (a_pend !== 8'h20) $display("FAIL basic_pending_held: got %h want 20", a_pend); else n_pass++;
    next_cyc();
    a_drive(1'b0, 3'd0, 1'b1, 8'hff, 1'b0);
    next_cyc();
    a_drive(1'b0, 3'd0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    n_chk++; if (a_pend !== 8'h00) $display("FAIL basic_ack_clear: got %h want 00", a_pend); else n_pass++;
  endtask

  task automatic test_backpressure();
    next_cyc();
    a_drive(1'b1, 3'd1, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    n_chk++; if (a_bus.idx_ready !== 1'b1) $display("FAIL bp_ready_c0: got %b want 1", a_bus.idx_ready); else n_pass++;
    next_cyc();
    @(negedge clk);
    n_chk++; if ({a_bus.idx_ready, a_strobe} !== {1'b0, 8'h02}) $display("FAIL bp_c1: got %b/%h want 0/02", a_bus.idx_ready, a_strobe); else n_pass++;
    next_cyc();
    @(negedge clk);
    n_chk++; if (a_bus.idx_ready !== 1'b0) $display("FAIL bp_ready_c2: got %b want 0", a_bus.idx_ready); else n_pass++;
    next_cyc();
    a_ack = 8'h02;
    @(negedge clk);
    n_chk++; if ({a_bus.idx_ready, a_strobe} !== {1'b1, 8'h00}) $display("FAIL bp_c3: got %b/%h want 1/00", a_bus.idx_ready, a_strobe); else n_pass++;
    next_cyc();
    a_drive(1'b0, 3'd0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    n_chk++; if (a_strobe !== 8'h02) $display("FAIL bp_strobe_c4: got %h want 02", a_strobe); else n_pass++;
    n_chk++; if ({a_pend, a_ovf} !== {8'h02, 1'b0}) $display("FAIL bp_pend_ovf: got %h/%b want 02/0", a_pend, a_ovf); else n_pass++;
    next_cyc();
    @(negedge clk);
    n_chk++; if (a_strobe !== 8'h02) $display("FAIL bp_strobe_c5: got %h want 02", a_strobe); else n_pass++;
    next_cyc();
    @(negedge clk);
    n_chk++; if ({a_strobe, a_busy} !== {8'h00, 1'b0}) $display("FAIL bp_end_c6: got %h/%b want 00/0", a_strobe, a_busy); else n_pass++;
    a_drive(1'b0, 3'd0, 1'b1, 8'hff, 1'b1);
    next_cyc();
    a_drive(1'b0, 3'd0, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_ack_race();
    next_cyc();
    a_drive(1'b1, 3'd3, 1'b1, 8'h00, 1'b0);
    next_cyc();
    a_drive(1'b0, 3'd0, 1'b1, 8'h00, 1'b0);
    repeat (2) next_cyc();
    a_drive(1'b1, 3'd3, 1'b1, 8'h08, 1'b0);
    @(negedge clk);
    n_chk++; if ({a_bus.idx_ready, a_pend} !== {1'b1, 8'h08}) $display("FAIL race_pre: got %b/%h want 1/08", a_bus.idx_ready, a_pend); else n_pass++;
    next_cyc();
    a_drive(1'b0, 3'd0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    n_chk++; if (a_pend !== 8'h08) $display("FAIL race_pending: got %h want 08", a_pend); else n_pass++;
    n_chk++; if (a_ovf !== 1'b0) $display("FAIL race_overflow: got %b want 0", a_ovf); else n_pass++;
    n_chk++; if (a_strobe !== 8'h08) $display("FAIL race_strobe: got %h want 08", a_strobe); else n_pass++;
    repeat (2) next_cyc();
    a_drive(1'b0, 3'd0, 1'b1, 8'hff, 1'b0);
    next_cyc();
    a_drive(1'b0, 3'd0, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_overflow();
    next_cyc();
    a_drive(1'b1, 3'd0, 1'b1, 8'h00, 1'b0);
    next_cyc();
    a_drive(1'b0, 3'd0, 1'b1, 8'h00, 1'b0);
    repeat (2) next_cyc();
    a_drive(1'b1, 3'd0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    n_chk++; if ({a_pend, a_ovf} !== {8'h01, 1'b0}) $display("FAIL ovf_pre: got %h/%b want 01/0", a_pend, a_ovf); else n_pass++;
    next_cyc();
    a_drive(1'b0, 3'd0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    n_chk++; if ({a_ovf, a_strobe} !== {1'b1, 8'h01}) $display("FAIL ovf_set: got %b/%h want 1/01", a_ovf, a_strobe); else n_pass++;
    next_cyc();
    @(negedge clk);
    n_chk++; if (a_strobe !== 8'h01) $display("FAIL ovf_strobe2: got %h want 01", a_strobe); else n_pass++;
    next_cyc();
    a_drive(1'b0, 3'd0, 1'b1, 8'h00, 1'b1);
    @(negedge clk);
    n_chk++; if ({a_ovf, a_strobe} !== {1'b1, 8'h00}) $display("FAIL ovf_sticky: got %b/%h want 1/00", a_ovf, a_strobe); else n_pass++;
    next_cyc();
    a_drive(1'b1, 3'd0, 1'b1, 8'h00, 1'b1);
    @(negedge clk);
    n_chk++; if (a_ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", a_ovf); else n_pass++;
    next_cyc();
    a_drive(1'b0, 3'd0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    n_chk++; if ({a_ovf, a_strobe} !== {1'b1, 8'h01}) $display("FAIL ovf_set_beats_clr: got %b/%h want 1/01", a_ovf, a_strobe); else n_pass++;
    repeat (2) next_cyc();
    a_drive(1'b0, 3'd0, 1'b1, 8'hff, 1'b1);
    next_cyc();
    a_drive(1'b0, 3'd0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    n_chk++; if ({a_pend, a_ovf} !== {8'h00, 1'b0}) $display("FAIL ovf_cleanup: got %h/%b want 00/0", a_pend, a_ovf); else n_pass++;
  endtask

  task automatic test_enable_low();
    next_cyc();
    a_drive(1'b1, 3'd7, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    n_chk++; if (a_bus.idx_ready !== 1'b1) $display("FAIL en_ready_c0: got %b want 1", a_bus.idx_ready); else n_pass++;
    next_cyc();
    a_drive(1'b0, 3'd0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    n_chk++; if ({a_bus.idx_ready, a_busy} !== 2'b10) $display("FAIL en_idle: got %b want 10", {a_bus.idx_ready, a_busy}); else n_pass++;
    n_chk++; if ({a_strobe, a_pend} !== 16'h0000) $display("FAIL en_no_event: got %h/%h want 00/00", a_strobe, a_pend); else n_pass++;
  endtask

  task automatic test_reset_midpulse();
    logic [7:0] exp_s;
    next_cyc();
    b_drive(1'b1, 3'd6, 8'h00);
    for (int k = 1; k <= PL_B + 1; k++) begin
      next_cyc();
      if (k == 1) b_drive(1'b0, 3'd0, 8'h00);
      @(negedge clk);
      exp_s = (k <= PL_B) ? 8'h40 : 8'h00;
      n_chk++; if (b_strobe !== exp_s) $display("FAIL len4_strobe_c%0d: got %h want %h", k, b_strobe, exp_s); else n_pass++;
    end
    next_cyc();
    b_drive(1'b0, 3'd0, 8'hff);
    next_cyc();
    b_drive(1'b1, 3'd2, 8'h00);
    next_cyc();
    b_drive(1'b0, 3'd0, 8'h00);
    @(negedge clk);
    n_chk++; if (b_strobe !== 8'h04) $display("FAIL mid_strobe1: got %h want 04", b_strobe); else n_pass++;
    next_cyc();
    b_rst = 1'b1;
    @(negedge clk);
    n_chk++; if ({b_strobe, b_bus.idx_ready} !== {8'h04, 1'b0}) $display("FAIL mid_strobe2: got %h/%b want 04/0", b_strobe, b_bus.idx_ready); else n_pass++;
    next_cyc();
    b_rst = 1'b0;
    @(negedge clk);
    n_chk++; if ({b_strobe, b_pend} !== 16'h0000) $display("FAIL mid_reset_clear: got %h/%h want 00/00", b_strobe, b_pend); else n_pass++;
    n_chk++; if ({b_busy, b_bus.idx_ready} !== 2'b01) $display("FAIL mid_reset_state: got %b want 01", {b_busy, b_bus.idx_ready}); else n_pass++;
    next_cyc();
    @(negedge clk);
    n_chk++; if (b_strobe !== 8'h00) $display("FAIL mid_no_residual: got %h want 00", b_strobe); else n_pass++;
  endtask

  // Model: a pulse accepted in cycle c occupies cycles c+1..c+PL_A; the
  // decoder is ready again once the current cycle number passes that window.
  task automatic test_random(input int n);
    int         p_start, p_end, p_line, c;
    logic [7:0] m_pend, e_strobe, set_vec;
    logic       m_ovf, e_ready, ev;
    a_rst = 1'b1;
    a_drive(1'b0, 3'd0, 1'b1, 8'h00, 1'b0);
    next_cyc();
    a_rst = 1'b0;
    m_pend  = 8'h00;
    m_ovf   = 1'b0;
    p_start = -10;
    p_end   = -10;
    p_line  = 0;
    repeat (n) begin
      next_cyc();
      a_bus.idx_valid = 1'($urandom_range(1));
      a_bus.idx       = 3'($urandom_range(7));
      a_en            = ($urandom_range(4) != 0);
      a_ack           = ($urandom_range(2) == 0) ? 8'($urandom) : 8'h00;
      a_clr           = ($urandom_range(5) == 0);
      @(negedge clk);
      c        = cyc;
      e_ready  = (c > p_end);
      e_strobe = (c >= p_start && c <= p_end) ? 8'(1 << p_line) : 8'h00;
      n_chk++; if (a_bus.idx_ready !== e_ready) $display("FAIL rnd_ready@%0d: got %b want %b", c, a_bus.idx_ready, e_ready); else n_pass++;
      n_chk++; if (a_strobe !== e_strobe) $display("FAIL rnd_strobe@%0d: got %h want %h", c, a_strobe, e_strobe); else n_pass++;
      n_chk++; if (a_busy !== (e_strobe != 8'h00)) $display("FAIL rnd_busy@%0d: got %b want %b", c, a_busy, (e_strobe != 8'h00)); else n_pass++;
      n_chk++; if (a_pend !== m_pend) $display("FAIL rnd_pending@%0d: got %h want %h", c, a_pend, m_pend); else n_pass++;
      n_chk++; if (a_ovf !== m_ovf) $display("FAIL rnd_overflow@%0d: got %b want %b", c, a_ovf, m_ovf); else n_pass++;
      ev      = a_bus.idx_valid && e_ready && a_en;
      set_vec = ev ? 8'(1 << a_bus.idx) : 8'h00;
      if (ev && m_pend[a_bus.idx] && !a_ack[a_bus.idx]) m_ovf = 1'b1;
      else if (a_clr) m_ovf = 1'b0;
      m_pend = (m_pend & ~a_ack) | set_vec;
      if (ev) begin
        p_start = c + 1;
        p_end   = c + PL_A;
        p_line  = int'(a_bus.idx);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    a_rst = 1'b1;
    b_rst = 1'b1;
    a_drive(1'b0, 3'd0, 1'b1, 8'h00, 1'b0);
    b_drive(1'b0, 3'd0, 8'h00);
    test_reset();
    test_basic();
    test_backpressure();
    test_ack_race();
    test_overflow();
    test_enable_low();
    test_reset_midpulse();
    test_random(400);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
